// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative MUL/DIV sequencer.
package muldiv_pkg;

  localparam int MD_DATA_W = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    MUL_IT,
    DIV_IT,
    FIX
  } state_e;

  // Low word reported for a divide by zero.
  localparam logic [MD_DATA_W-1:0] DIV0_LO = '1;

  // Width of a counter that must hold the value w.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_w(MD_DATA_W);

endpackage

// File: rtl/muldiv_seq_if.sv
// Start/operand/result bundle between the control unit and the sequencer.
interface muldiv_seq_if #(
  parameter int DATA_W = 32
);
  logic              iStart;
  logic              iOp;
  logic [DATA_W-1:0] iA;
  logic [DATA_W-1:0] iB;
  logic              oBusy;
  logic              oDone;
  logic              oDivZero;
  logic [DATA_W-1:0] oHi;
  logic [DATA_W-1:0] oLo;

  modport master (
    output iStart, iOp, iA, iB,
    input  oBusy, oDone, oDivZero, oHi, oLo
  );

  modport slave (
    input  iStart, iOp, iA, iB,
    output oBusy, oDone, oDivZero, oHi, oLo
  );
endinterface

// File: rtl/muldiv_abs.sv
// Magnitude and sign of a two's complement operand. The most negative value
// maps onto itself and is then read as an unsigned magnitude.
module muldiv_abs #(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] val_i,
  output logic        [DATA_W-1:0] mag_o,
  output logic                     neg_o
);

  assign neg_o = val_i[DATA_W-1];
  assign mag_o = neg_o ? (~val_i + 1'b1) : val_i;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative signed MUL/DIV sequencer: shift-add multiply and restoring divide
// on operand magnitudes, followed by a one-cycle sign fix-up.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W
) (
  input  logic         iClk,
  input  logic         nRst,
  muldiv_seq_if.slave  bus
);

  localparam int CW = cnt_w(DATA_W);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                op_q, op_d;
  logic                sa_q, sa_d;
  logic                sb_q, sb_d;
  logic                dz_q, dz_d;
  logic                hold_q, hold_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W:0]     acc_q, acc_d;
  logic [DATA_W-1:0]   wrk_q, wrk_d;
  logic [DATA_W-1:0]   araw_q, araw_d;
  logic [DATA_W-1:0]   res_hi_q, res_hi_d;
  logic [DATA_W-1:0]   res_lo_q, res_lo_d;
  logic                divz_q, divz_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   a_mag, b_mag;
  logic                a_neg, b_neg;
  logic [DATA_W:0]     mul_sum, div_sh, div_diff;
  logic [2*DATA_W-1:0] prod;

  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg_w2(input logic [2*DATA_W-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  muldiv_abs #(.DATA_W(DATA_W)) u_abs_a (.val_i(bus.iA), .mag_o(a_mag), .neg_o(a_neg));
  muldiv_abs #(.DATA_W(DATA_W)) u_abs_b (.val_i(bus.iB), .mag_o(b_mag), .neg_o(b_neg));

  // State register.
  always_ff @(posedge iClk) begin
    if (!nRst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, iteration datapath and result fix-up.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dz_d     = dz_q;
    hold_d   = hold_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    wrk_d    = wrk_q;
    araw_d   = araw_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    divz_d   = divz_q;
    done_d   = 1'b0;
    mul_sum  = wrk_q[0] ? (acc_q + {1'b0, mcand_q}) : acc_q;
    div_sh   = {acc_q[DATA_W-1:0], wrk_q[DATA_W-1]};
    div_diff = div_sh - {1'b0, mcand_q};
    prod     = {acc_q[DATA_W-1:0], wrk_q};
    unique case (state_q)
      IDLE: begin
        if (bus.iStart) begin
          op_d   = bus.iOp;
          sa_d   = a_neg;
          sb_d   = b_neg;
          araw_d = bus.iA;
          acc_d  = '0;
          cnt_d  = CW'(DATA_W);
          divz_d = 1'b0;
          // MUL: multiplicand in mcand, multiplier in wrk.
          // DIV: divisor in mcand, dividend shifts out of wrk as quotient shifts in.
          mcand_d = (bus.iOp == OP_MUL) ? a_mag : b_mag;
          wrk_d   = (bus.iOp == OP_MUL) ? b_mag : a_mag;
          dz_d    = (bus.iOp == OP_DIV) && (b_mag == '0);
          // Divide by zero skips iterating but spends one extra cycle in FIX.
          hold_d  = dz_d;
          if (bus.iOp == OP_MUL) state_d = MUL_IT;
          else if (dz_d)         state_d = FIX;
          else                   state_d = DIV_IT;
        end
      end
      MUL_IT: begin
        acc_d = {1'b0, mul_sum[DATA_W:1]};
        wrk_d = {mul_sum[0], wrk_q[DATA_W-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      DIV_IT: begin
        wrk_d = {wrk_q[DATA_W-2:0], 1'b0};
        if (!div_diff[DATA_W]) begin
          acc_d    = div_diff;
          wrk_d[0] = 1'b1;
        end else begin
          acc_d = div_sh;
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          if (dz_q) begin
            res_hi_d = araw_q;
            res_lo_d = {DATA_W{DIV0_LO[0]}};
          end else if (op_q == OP_MUL) begin
            {res_hi_d, res_lo_d} = neg_w2(prod, sa_q ^ sb_q);
          end else begin
            res_lo_d = neg_w(wrk_q, sa_q ^ sb_q);
            res_hi_d = neg_w(acc_q[DATA_W-1:0], sa_q);
          end
          divz_d  = dz_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath, counter and result registers; reset clears everything.
  always_ff @(posedge iClk) begin
    if (!nRst) begin
      cnt_q    <= '0;
      op_q     <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      hold_q   <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      wrk_q    <= '0;
      araw_q   <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      divz_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dz_q     <= dz_d;
      hold_q   <= hold_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      wrk_q    <= wrk_d;
      araw_q   <= araw_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      divz_q   <= divz_d;
      done_q   <= done_d;
    end
  end

  assign bus.oBusy    = (state_q != IDLE);
  assign bus.oDone    = done_q;
  assign bus.oDivZero = divz_q;
  assign bus.oHi      = res_hi_q;
  assign bus.oLo      = res_lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a result scoreboard.
module tb_muldiv_seq;

  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic          dz;
  } res_t;

  logic iClk = 1'b0;
  logic nRst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  res_t drop;
  logic seen;

  muldiv_seq_if #(.DATA_W(DW)) bus ();

  muldiv_seq #(.DATA_W(DW)) dut (
    .iClk (iClk),
    .nRst (nRst),
    .bus  (bus)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model using wide signed arithmetic.
  function automatic res_t model(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    res_t        r;
    longint      sa, sbv, q, rm;
    logic [63:0] p;
    sa   = longint'($signed(a));
    sbv  = longint'($signed(b));
    r.dz = 1'b0;
    if (op == 1'b0) begin
      p    = sa * sbv;
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else if (b == '0) begin
      r.hi = a;
      r.lo = '1;
      r.dz = 1'b1;
    end else begin
      q    = sa / sbv;
      rm   = sa % sbv;
      p    = q;
      r.lo = p[31:0];
      p    = rm;
      r.hi = p[31:0];
    end
    return r;
  endfunction

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic start(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.iStart = 1'b1;
    bus.iOp    = op;
    bus.iA     = a;
    bus.iB     = b;
    sb.push_back(model(op, a, b));
    @(posedge iClk);
    #1;
    bus.iStart = 1'b0;
    bus.iA     = $urandom;
    bus.iB     = $urandom;
  endtask

  // Waits for oDone, checks latency from the current point and pops the result.
  task automatic wait_done(input string tag, input int exp_lat);
    int   lat;
    res_t e;
    lat = 0;
    for (int n = 1; n <= exp_lat + 8; n++) begin
      @(posedge iClk);
      #1;
      if (bus.oDone) begin
        lat = n;
        break;
      end
    end
    chk({tag, ".latency"}, lat, exp_lat);
    if (sb.size() != 0) e = sb.pop_front();
    else e = '0;
    chk({tag, ".hi"}, bus.oHi, e.hi);
    chk({tag, ".lo"}, bus.oLo, e.lo);
    chk({tag, ".divzero"}, bus.oDivZero, e.dz);
    chk({tag, ".busy_low"}, bus.oBusy, 1'b0);
  endtask

  initial begin
    bus.iStart = 1'b0;
    bus.iOp    = 1'b0;
    bus.iA     = '0;
    bus.iB     = '0;
    nRst       = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    chk("rst.busy", bus.oBusy, 1'b0);
    chk("rst.done", bus.oDone, 1'b0);
    chk("rst.divzero", bus.oDivZero, 1'b0);
    chk("rst.hi", bus.oHi, 32'h0);
    chk("rst.lo", bus.oLo, 32'h0);
    nRst = 1'b1;
    @(posedge iClk);
    #1;

    start(1'b0, 32'd10, 32'd5);
    chk("mul10x5.busy", bus.oBusy, 1'b1);
    wait_done("mul10x5", 33);
    chk("mul10x5.lo_abs", bus.oLo, 32'd50);
    @(posedge iClk);
    #1;
    chk("mul10x5.pulse_width", bus.oDone, 1'b0);

    start(1'b0, -32'sd7, 32'd3);
    wait_done("mul_m7x3", 33);
    chk("mul_m7x3.hi_abs", bus.oHi, 32'hFFFFFFFF);
    chk("mul_m7x3.lo_abs", bus.oLo, 32'hFFFFFFEB);

    start(1'b0, 32'h80000000, 32'h80000000);
    wait_done("mul_min_sq", 33);
    chk("mul_min_sq.hi_abs", bus.oHi, 32'h40000000);

    start(1'b1, -32'sd17, 32'd5);
    wait_done("div_m17_5", 33);
    chk("div_m17_5.lo_abs", bus.oLo, 32'hFFFFFFFD);
    chk("div_m17_5.hi_abs", bus.oHi, 32'hFFFFFFFE);

    start(1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_min_m1", 33);
    chk("div_min_m1.lo_abs", bus.oLo, 32'h80000000);

    start(1'b1, 32'd42, 32'd0);
    wait_done("div0", 2);
    chk("div0.hi_abs", bus.oHi, 32'd42);
    @(posedge iClk);
    #1;
    chk("div0.pulse_width", bus.oDone, 1'b0);
    chk("div0.flag_holds", bus.oDivZero, 1'b1);

    // Start while busy must be ignored.
    start(1'b0, 32'd123, -32'sd456);
    chk("ign.divzero_cleared", bus.oDivZero, 1'b0);
    repeat (9) @(posedge iClk);
    #1;
    bus.iStart = 1'b1;
    bus.iOp    = 1'b1;
    bus.iA     = 32'd100;
    bus.iB     = 32'd0;
    @(posedge iClk);
    #1;
    bus.iStart = 1'b0;
    chk("ign.busy", bus.oBusy, 1'b1);
    wait_done("ign_mul", 23);

    // Back-to-back start in the oDone cycle.
    start(1'b1, 32'd1000, -32'sd7);
    chk("b2b.busy", bus.oBusy, 1'b1);
    chk("b2b.done_dropped", bus.oDone, 1'b0);
    wait_done("b2b_div", 33);

    // Reset in the middle of an operation.
    start(1'b0, 32'd55, 32'd66);
    repeat (14) @(posedge iClk);
    #1;
    nRst = 1'b0;
    @(posedge iClk);
    #1;
    nRst = 1'b1;
    chk("abort.busy", bus.oBusy, 1'b0);
    chk("abort.hi", bus.oHi, 32'h0);
    chk("abort.lo", bus.oLo, 32'h0);
    chk("abort.done", bus.oDone, 1'b0);
    drop = sb.pop_front();
    seen = 1'b0;
    repeat (40) begin
      @(posedge iClk);
      #1;
      if (bus.oDone) seen = 1'b1;
    end
    chk("abort.no_done", seen, 1'b0);

    start(1'b0, 32'd6, 32'd7);
    wait_done("mul6x7", 33);
    chk("mul6x7.lo_abs", bus.oLo, 32'd42);
    chk("scoreboard.empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
